// File: rtl/picorv32_trace_drain.sv
// Trace drain engine: freezes the trace buffer, reads the stored entries
// oldest-first from the trace memory and streams them out one per beat.
module picorv32_trace_drain #(
  parameter logic [31:0] TRACE_BASEADDR     = 32'h00100000,
  parameter int unsigned TRACE_ENTRIES      = 1024,
  parameter int unsigned PICO_MEM_ADDR_SIZE = 32,
  parameter int unsigned ASM_MEM_DATA_SIZE  = 128
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          trace_enable_req_i,
  output logic                          trace_enabled_o,
  input  logic [PICO_MEM_ADDR_SIZE-1:0] trace_ptr_i,
  input  logic [PICO_MEM_ADDR_SIZE-1:0] trace_count_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  output logic                          mem_en_o,
  output logic [PICO_MEM_ADDR_SIZE-1:0] mem_addr_o,
  input  logic [ASM_MEM_DATA_SIZE-1:0]  mem_rdata_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          out_last_o,
  output logic [63:0]                   out_data_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned IDX_W = (TRACE_ENTRIES > 1) ? $clog2(TRACE_ENTRIES) : 1;
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned AW    = PICO_MEM_ADDR_SIZE;
  localparam int unsigned DW    = ASM_MEM_DATA_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPT, S_OUT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DW-1:0]    row_q, row_d;
  logic             busy_d, done_d, mem_en_d, out_valid_d, out_last_d;
  logic [AW-1:0]    mem_addr_d;
  logic [63:0]      out_data_d;
  logic [CNT_W-1:0] snap_n;
  logic [IDX_W-1:0] snap_first, idx_inc;
  logic             unused_bits;

  // Selects one 36-bit entry out of a 128-bit row (even slot low, odd slot at bit 64).
  function automatic logic [63:0] pick_entry(input logic [DW-1:0] row, input logic odd);
    return odd ? {28'b0, row[99:64]} : {28'b0, row[35:0]};
  endfunction

  // Byte address of the row holding entry i (two entries per 16-byte row).
  function automatic logic [AW-1:0] row_addr(input logic [IDX_W-1:0] i);
    return AW'(TRACE_BASEADDR) + (AW'(i >> 1) << 4);
  endfunction

  assign trace_enabled_o = trace_enable_req_i & ~busy_o;
  assign idx_inc         = idx_q + IDX_W'(1);
  assign unused_bits     = ^{trace_ptr_i, mem_rdata_i};

  // Snapshot of entry count (clamped to buffer depth) and oldest entry index.
  always_comb begin
    if (trace_count_i >= AW'(TRACE_ENTRIES)) snap_n = CNT_W'(TRACE_ENTRIES);
    else                                     snap_n = CNT_W'(trace_count_i);
    snap_first = trace_ptr_i[IDX_W-1:0] - snap_n[IDX_W-1:0];
  end

  // Next-state and next-output logic; abort overrides everything while busy.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    row_d       = row_q;
    done_d      = 1'b0;
    mem_en_d    = 1'b0;
    mem_addr_d  = '0;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_last_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (snap_n == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = S_READ;
            idx_d      = snap_first;
            rem_d      = snap_n;
            mem_en_d   = 1'b1;
            mem_addr_d = row_addr(snap_first);
          end
        end
      end
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        row_d       = mem_rdata_i;
        state_d     = S_OUT;
        out_valid_d = 1'b1;
        out_data_d  = pick_entry(mem_rdata_i, idx_q[0]);
        out_last_d  = (rem_q == CNT_W'(1));
      end
      S_OUT: begin
        out_valid_d = out_valid_o;
        out_data_d  = out_data_o;
        out_last_d  = out_last_o;
        if (out_ready_i) begin
          rem_d = rem_q - CNT_W'(1);
          idx_d = idx_inc;
          if (rem_q == CNT_W'(1)) begin
            state_d     = S_IDLE;
            done_d      = 1'b1;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
          end else if (!idx_q[0]) begin
            out_data_d = pick_entry(row_q, 1'b1);
            out_last_d = (rem_q == CNT_W'(2));
          end else begin
            state_d     = S_READ;
            mem_en_d    = 1'b1;
            mem_addr_d  = row_addr(idx_inc);
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      done_d      = 1'b0;
      mem_en_d    = 1'b0;
      mem_addr_d  = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, counters, row buffer and all registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      row_q       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      mem_en_o    <= 1'b0;
      mem_addr_o  <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      row_q       <= row_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      mem_en_o    <= mem_en_d;
      mem_addr_o  <= mem_addr_d;
      out_valid_o <= out_valid_d;
      out_data_o  <= out_data_d;
      out_last_o  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_picorv32_trace_drain.sv
// Directed bench for picorv32_trace_drain with a behavioural trace memory.
module tb_picorv32_trace_drain;

  localparam logic [31:0] BASE = 32'h00100000;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         trace_enable_req_i = 1'b1;
  logic         trace_enabled_o;
  logic [31:0]  trace_ptr_i = '0;
  logic [31:0]  trace_count_i = '0;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic         mem_en_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_rdata_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b1;
  logic         out_last_o;
  logic [63:0]  out_data_o;
  logic         busy_o;
  logic         done_o;

  int passed = 0;
  int total  = 0;
  logic [31:0] rd_q[$];

  picorv32_trace_drain dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .trace_enable_req_i(trace_enable_req_i), .trace_enabled_o(trace_enabled_o),
    .trace_ptr_i(trace_ptr_i), .trace_count_i(trace_count_i),
    .start_i(start_i), .abort_i(abort_i),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_last_o(out_last_o),
    .out_data_o(out_data_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Entry contents are a fixed function of the entry index.
  function automatic logic [35:0] ent(input int e);
    return {4'hC, 16'hBEEF ^ 16'(e), 16'(e)};
  endfunction

  function automatic logic [127:0] row_for(input int r);
    return {28'hDEADBEE, ent(2 * r + 1), 28'hFACEFEE, ent(2 * r)};
  endfunction

  // Trace memory: one-cycle read latency; every read address is logged.
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      rd_q.push_back(mem_addr_o);
      mem_rdata_i <= row_for(int'((mem_addr_o - BASE) >> 4) % 512);
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic start_drain(input int count, input int ptr);
    trace_count_i = 32'(count);
    trace_ptr_i   = 32'(ptr);
    rd_q.delete();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Consume n beats with ready held high, starting at the first OUT cycle.
  task automatic drain(input string tag, input int n, input int first);
    int beats = 0;
    int errs  = 0;
    int cyc   = 0;
    int rerr  = 0;
    int ri    = 0;
    int e     = first;
    while (beats < n && cyc < 4 * n + 20) begin
      if (out_valid_o) begin
        if (out_data_o !== {28'b0, ent(e)}) errs++;
        if (out_last_o !== (beats == n - 1)) errs++;
        if (trace_enabled_o !== 1'b0) errs++;
        beats++;
        e = (e + 1) % 1024;
      end
      if (mem_en_o && out_valid_o) errs++;
      tick();
      cyc++;
    end
    check({tag, "_beats"}, 64'(beats), 64'(n));
    check({tag, "_beat_errs"}, 64'(errs), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd1);
    check({tag, "_busy_end"}, 64'(busy_o), 64'd0);
    check({tag, "_valid_end"}, 64'(out_valid_o), 64'd0);
    for (int k = 0; k < n; k++) begin
      int ee = (first + k) % 1024;
      if (k == 0 || ee % 2 == 0) begin
        if (ri >= rd_q.size() || rd_q[ri] !== BASE + 32'((ee >> 1) * 16)) rerr++;
        ri++;
      end
    end
    check({tag, "_reads"}, 64'(rd_q.size()), 64'(ri));
    check({tag, "_read_addr_errs"}, 64'(rerr), 64'd0);
    tick();
    check({tag, "_done_pulse"}, 64'(done_o), 64'd0);
  endtask

  task automatic run(input string tag, input int count, input int ptr,
                     input int n, input int first, input logic [31:0] first_addr);
    start_drain(count, ptr);
    check({tag, "_busy"}, 64'(busy_o), 64'd1);
    check({tag, "_mem_en"}, 64'(mem_en_o), 64'd1);
    check({tag, "_first_addr"}, 64'(mem_addr_o), 64'(first_addr));
    tick();
    check({tag, "_lat_capt"}, 64'(out_valid_o), 64'd0);
    tick();
    check({tag, "_lat_out"}, 64'(out_valid_o), 64'd1);
    drain(tag, n, first);
  endtask

  initial begin
    int errs;
    tick();
    tick();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_mem_en", 64'(mem_en_o), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_data", out_data_o, 64'd0);
    check("rst_last", 64'(out_last_o), 64'd0);
    check("rst_trace_en", 64'(trace_enabled_o), 64'd1);
    reset_i = 1'b0;
    tick();

    // Three entries, buffer not wrapped: rows 0 and 1 read.
    run("short", 3, 3, 3, 0, BASE);
    check("short_rd0", 64'(rd_q[0]), 64'(BASE));
    check("short_rd1", 64'(rd_q[1]), 64'(BASE + 32'h10));

    // Full buffer, ptr=5: oldest is entry 5 in row 2, wraps through row 0.
    run("full", 1024, 5, 1024, 5, BASE + 32'h20);

    // Empty buffer: immediate done, nothing read or streamed.
    start_drain(0, 7);
    check("empty_done", 64'(done_o), 64'd1);
    check("empty_busy", 64'(busy_o), 64'd0);
    check("empty_mem_en", 64'(mem_en_o), 64'd0);
    check("empty_valid", 64'(out_valid_o), 64'd0);
    tick();
    check("empty_done_pulse", 64'(done_o), 64'd0);
    check("empty_reads", 64'(rd_q.size()), 64'd0);

    // Backpressure for 10 cycles in OUT, then abort with ready high.
    out_ready_i = 1'b0;
    start_drain(4, 4);
    tick();
    tick();
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid_o !== 1'b1) errs++;
      if (out_data_o !== {28'b0, ent(0)}) errs++;
      if (out_last_o !== 1'b0) errs++;
      if (mem_en_o !== 1'b0) errs++;
      if (trace_enabled_o !== 1'b0) errs++;
      tick();
    end
    check("stall_errs", 64'(errs), 64'd0);
    check("stall_reads", 64'(rd_q.size()), 64'd1);
    abort_i = 1'b1;
    out_ready_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("stall_abort_valid", 64'(out_valid_o), 64'd0);
    check("stall_abort_busy", 64'(busy_o), 64'd0);

    // Abort on beat 2 of 8.
    start_drain(8, 8);
    tick();
    tick();
    check("abort_beat1", out_data_o, {28'b0, ent(0)});
    tick();
    check("abort_beat2", out_data_o, {28'b0, ent(1)});
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_valid", 64'(out_valid_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_done", 64'(done_o), 64'd0);
    check("abort_trace_en", 64'(trace_enabled_o), 64'd1);
    tick();
    check("abort_no_done", 64'(done_o), 64'd0);

    // Asynchronous reset mid-drain.
    start_drain(8, 8);
    tick();
    tick();
    check("rstmid_pre_valid", 64'(out_valid_o), 64'd1);
    #2;
    reset_i = 1'b1;
    #1;
    check("rstmid_valid", 64'(out_valid_o), 64'd0);
    check("rstmid_busy", 64'(busy_o), 64'd0);
    check("rstmid_data", out_data_o, 64'd0);
    check("rstmid_addr", 64'(mem_addr_o), 64'd0);
    check("rstmid_trace_en", 64'(trace_enabled_o), 64'd1);
    trace_enable_req_i = 1'b0;
    #1;
    check("rstmid_trace_off", 64'(trace_enabled_o), 64'd0);
    tick();
    reset_i = 1'b0;
    trace_enable_req_i = 1'b1;
    tick();

    // Drain after reset still works from a clean state.
    run("post", 2, 2, 2, 0, BASE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
